// File: rtl/shiftadd_mult_serial.sv
// Serial radix-2 shift-and-add multiplier, one partial product per clock.
// Ports: clk_i, rst_i (sync, active-high), start_i, a_i, b_i -> busy_o, result_o, valid_o.
// Optional macro SHIFTADD_MULT_EARLY_TERM_EN: stop once the remaining multiplier bits are zero.
package multiplier_pkg;
  localparam int DATA_LENGTH = 64;
endpackage

module shiftadd_mult_serial #(
  parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH,
  parameter int OP_LENGTH   = DATA_LENGTH / 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [OP_LENGTH-1:0]   a_i,
  input  logic [OP_LENGTH-1:0]   b_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o
);

  localparam int CW = $clog2(OP_LENGTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                 state;
  logic [DATA_LENGTH-1:0] mcand;
  logic [DATA_LENGTH-1:0] acc;
  logic [OP_LENGTH-1:0]   mplier;
  logic [CW-1:0]          cnt;

  logic [DATA_LENGTH-1:0] acc_nxt;
  logic                   last_iter;

  // Accumulator value after the iteration performed at this edge.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    last_iter = (cnt == CW'(OP_LENGTH - 1));
`ifdef SHIFTADD_MULT_EARLY_TERM_EN
    // Remaining multiplier bits all zero: further iterations add nothing.
    last_iter = last_iter | ((mplier >> 1) == '0);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            mcand  <= DATA_LENGTH'(a_i);
            mplier <= b_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            result_o <= acc_nxt;
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult_serial.sv
// Scoreboard bench for shiftadd_mult_serial: random and directed operands
// checked against plain a*b and a bit-length latency model.
module tb_shiftadd_mult_serial;

  localparam int DL = 64;
  localparam int OP = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [OP-1:0] a_i;
  logic [OP-1:0] b_i;
  logic          busy_o;
  logic          valid_o;
  logic [DL-1:0] result_o;

  shiftadd_mult_serial #(
    .DATA_LENGTH(DL),
    .OP_LENGTH(OP)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .result_o(result_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DL-1:0] prod;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;
  logic [DL-1:0] hold = '0;
  bit            mon_en = 1'b0;

  // cyc = index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DL-1:0] act,
                       input logic [DL-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, cyc);
  endtask

  // Iterations needed for multiplier b.
  function automatic int iters(input logic [OP-1:0] b);
    int bl;
    bl = 0;
    for (int i = 0; i < OP; i++) if (b[i]) bl = i + 1;
`ifdef SHIFTADD_MULT_EARLY_TERM_EN
    return (bl == 0) ? 1 : bl;
`else
    return OP;
`endif
  endfunction

  // Monitor: busy tracks outstanding work, each valid pops one product,
  // result holds between completions.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy", DL'(busy_o), DL'(sb.size() != 0));
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("spurious_valid", DL'(1), DL'(0));
        end else begin
          e = sb.pop_front();
          check("product", result_o, e.prod);
          check("latency", DL'(cyc), DL'(e.due));
          hold = e.prod;
        end
      end else begin
        check("result_hold", result_o, hold);
      end
    end
  end

  // Start accepted at edge E0; valid is visible after edge E0+N
  // (the (N+1)th cycle counting the start cycle).
  task automatic do_op(input logic [OP-1:0] a, input logic [OP-1:0] b);
    exp_t e;
    @(negedge clk);
    start_i = 1'b1;
    a_i = a;
    b_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    e.prod = DL'(a) * DL'(b);
    e.due = cyc + iters(b);
    sb.push_back(e);
    a_i = $urandom;
    b_i = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", DL'(0), DL'(1));
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   e0;
    logic [OP-1:0] ra;
    logic [OP-1:0] rb;
    rst_i = 1'b1;
    start_i = 1'b1;
    a_i = 32'h5;
    b_i = 32'h5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", DL'(busy_o), DL'(0));
    check("reset_valid", DL'(valid_o), DL'(0));
    check("reset_result", result_o, DL'(0));
    @(negedge clk);
    rst_i = 1'b0;
    start_i = 1'b0;
    mon_en = 1'b1;

    do_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    do_op(32'd3, 32'd5);
    wait_idle();
    do_op(32'h12345678, 32'd0);
    wait_idle();
    do_op(32'h12345678, 32'd1);
    wait_idle();
    do_op(32'h0, 32'h80000001);
    wait_idle();

    // Start pulse while busy is ignored.
    do_op(32'd2, 32'd3);
    @(negedge clk);
    start_i = 1'b1;
    a_i = 32'd7;
    b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    do_op(32'd7, 32'd7);
    wait_idle();

    // Start held high: next op accepted N+2 edges after the first.
    do_op(32'd11, 32'hF0);
    e0 = sb[0].due - iters(32'hF0);
    start_i = 1'b1;
    a_i = 32'hABCD;
    b_i = 32'h1234;
    while (cyc < e0 + iters(32'hF0) + 2) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    e.prod = DL'(32'hABCD) * DL'(32'h1234);
    e.due = cyc + iters(32'h1234);
    sb.push_back(e);
    a_i = $urandom;
    b_i = $urandom;
    wait_idle();

    // Reset mid-operation aborts without a valid.
    do_op(32'h9ABCDEF1, 32'h80000003);
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    hold = '0;
    check("abort_busy", DL'(busy_o), DL'(0));
    check("abort_result", result_o, DL'(0));
    @(negedge clk);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);
    do_op(32'd1000, 32'd1000);
    wait_idle();

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      do_op(ra, rb);
      wait_idle();
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
